// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_if
// Purpose  : Request/acknowledge data-memory bus between dmem_bridge (master)
//            and a variable-latency memory (slave).
// Signals  : bus_req   - access request, high for the whole request phase
//            bus_we    - byte write enables (0 = load)
//            bus_addr  - word-aligned address
//            bus_wdata - lane-shifted store data
//            bus_ack   - 1-cycle completion pulse from the memory
//            bus_rdata - load data, valid while bus_ack = 1
//            bus_err   - timeout pulse (constant 0 without the timeout build)
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req;
    logic [3:0]            bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_ack;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_err,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_err,
        output bus_ack,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Purpose  : Converts the MEM-stage RAM controls into a request/acknowledge
//            data-memory bus access, stalls the pipeline until the access
//            completes and returns byte-extracted, sign/zero-extended load
//            data to WB.
// Ports    : clk            - clock, rising edge
//            rst            - synchronous reset, active low
//            ram_en         - access request from MEM
//            ram_write_en   - byte write enables (0 = load)
//            ram_addr       - word-aligned address
//            ram_write_data - lane-shifted store data
//            byte_offset    - address[1:0] of the access
//            mem_sel        - size: 4'b0001 byte, 4'b1111 word
//            mem_sign_ext   - sign-extend byte loads
//            stall_req      - holds IF..MEM while an access is pending
//            read_data      - aligned/extended load result to WB
//            bus            - dmem_bridge_if master modport
// Options  : DMEM_TIMEOUT_EN - when defined, a request that is not acknowledged
//            within TIMEOUT_CYCLES cycles is force-completed and bus_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  ram_en,
    input  wire logic [3:0]            ram_write_en,
    input  wire logic [ADDR_WIDTH-1:0] ram_addr,
    input  wire logic [DATA_WIDTH-1:0] ram_write_data,
    input  wire logic [1:0]            byte_offset,
    input  wire logic [3:0]            mem_sel,
    input  wire logic                  mem_sign_ext,
    output logic                       stall_req,
    output logic [DATA_WIDTH-1:0]      read_data,
    dmem_bridge_if.master              bus
);

    localparam logic [3:0] c_SEL_BYTE = 4'b0001;
    localparam logic [3:0] c_SEL_WORD = 4'b1111;

    // The counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_stall;
    logic                  w_timeout;

    // Access captured in IDLE; the bus sees only these during REQ.
    logic [3:0]            r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_off;
    logic [3:0]            r_sel;
    logic                  r_sext;
    logic [DATA_WIDTH-1:0] r_read_data;

    logic [7:0]            w_lane;
    logic [DATA_WIDTH-1:0] w_extracted;

    // ------------------------------------------------------------------
    // Optional request timeout
    // ------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
    // The counter reads 0 in the first REQ cycle, so the last allowed REQ
    // cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    // An ack arriving on the last cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_REQ) && !bus.bus_ack && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
            // Set on the edge into DONE, so it is high for the DONE cycle only.
            r_err <= w_timeout;
        end
    end

    assign bus.bus_err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load extraction from the captured offset/size
    // ------------------------------------------------------------------
    always_comb begin
        w_lane      = bus.bus_rdata[{r_off, 3'b000} +: 8];
        w_extracted = '0;
        case (r_sel)
            c_SEL_BYTE: w_extracted = {{(DATA_WIDTH-8){r_sext & w_lane[7]}}, w_lane};
            c_SEL_WORD: w_extracted = bus.bus_rdata;
            default:    w_extracted = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and stall logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = ram_en;
                if (ram_en) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (bus.bus_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            // ram_en still shows the finished access here, so it is ignored.
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_we        <= 4'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_off       <= 2'b0;
            r_sel       <= 4'b0;
            r_sext      <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && ram_en) begin
                r_we    <= ram_write_en;
                r_addr  <= ram_addr;
                r_wdata <= ram_write_data;
                r_off   <= byte_offset;
                r_sel   <= mem_sel;
                r_sext  <= mem_sign_ext;
            end

            // Only loads update the result; stores leave it untouched.
            if (r_state == S_REQ && r_we == 4'b0) begin
                if (bus.bus_ack) begin
                    r_read_data <= w_extracted;
                end else if (w_timeout) begin
                    r_read_data <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_req     = rst & w_stall;
    assign read_data     = r_read_data;
    assign bus.bus_req   = (r_state == S_REQ);
    assign bus.bus_we    = (r_state == S_REQ) ? r_we : 4'b0;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Purpose  : Self-checking bench for dmem_bridge. A driver issues accesses and
//            plays the memory; each access pushes its expected outcome into a
//            scoreboard queue that an independent monitor pops at completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

    localparam int c_DW = 32;
    localparam int c_AW = 32;
`ifdef DMEM_TIMEOUT_EN
    localparam int c_TO = 8;
`else
    localparam int c_TO = 255;
`endif

    logic        clk            = 1'b0;
    logic        rst            = 1'b0;
    logic        ram_en         = 1'b0;
    logic [3:0]  ram_write_en   = 4'b0;
    logic [31:0] ram_addr       = '0;
    logic [31:0] ram_write_data = '0;
    logic [1:0]  byte_offset    = 2'b0;
    logic [3:0]  mem_sel        = 4'b0;
    logic        mem_sign_ext   = 1'b0;
    logic        stall_req;
    logic [31:0] read_data;

    dmem_bridge_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus_if ();

    dmem_bridge #(
        .DATA_WIDTH     (c_DW),
        .ADDR_WIDTH     (c_AW),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .byte_offset    (byte_offset),
        .mem_sel        (mem_sel),
        .mem_sign_ext   (mem_sign_ext),
        .stall_req      (stall_req),
        .read_data      (read_data),
        .bus            (bus_if)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          stall;
        int          req;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] model_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Reference load result: pick the addressed byte with plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [3:0] sel, input logic [1:0] off,
                                             input logic sext, input logic [31:0] rdata);
        longint unsigned v;
        longint unsigned b;
        v = rdata;
        if (sel == 4'b1111) return rdata;
        if (sel == 4'b0001) begin
            b = (v >> (8 * off)) % 256;
            if (sext && b >= 128) return 32'hFFFF_FF00 | 32'(b);
            return 32'(b);
        end
        return 32'h0;
    endfunction

    // lat = k: ack in the k-th REQ cycle; lat = 0: never ack (timeout build).
    // Starts and ends at a falling edge with the DUT idle.
    task automatic do_access(input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] off,
                             input logic [3:0] sel, input logic sext,
                             input logic [31:0] rdata, input int lat, input bit b2b);
        exp_t e;
        int   limit;
        limit   = (lat == 0) ? c_TO : lat;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        e.stall = 1 + limit;
        e.req   = limit;
        e.err   = (lat == 0);
        if (we == 4'b0) model_rd = (lat == 0) ? 32'h0 : ref_load(sel, off, sext, rdata);
        e.rd    = model_rd;
        sb_q.push_back(e);

        ram_en = 1'b1; ram_write_en = we; ram_addr = addr; ram_write_data = wdata;
        byte_offset = off; mem_sel = sel; mem_sign_ext = sext;
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            // The stalled pipeline may change its inputs; the bus must not follow.
            ram_write_en   = 4'($urandom);
            ram_addr       = $urandom;
            ram_write_data = $urandom;
            byte_offset    = 2'($urandom);
            mem_sel        = 4'($urandom);
            mem_sign_ext   = 1'($urandom);
            bus_if.bus_rdata = $urandom;
            if (k == lat) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = rdata;
            end
            @(posedge clk);
        end
        @(negedge clk);                 // DONE
        bus_if.bus_ack = 1'b0;
        ram_en = b2b;
        @(posedge clk);
        @(negedge clk);                 // IDLE
    endtask

    // Monitor: samples 2 time units after the falling edge.
    initial begin : monitor
        int   run;
        int   req;
        exp_t e;
        run = 0;
        req = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                run = 0;
                req = 0;
            end else begin
                if (bus_if.bus_req === 1'b1) begin
                    req++;
                    if (sb_q.size() == 0) begin
                        check("req_without_access", 32'd1, 32'd0);
                    end else begin
                        check("bus_addr_hold", bus_if.bus_addr, sb_q[0].addr);
                        check("bus_we_hold", {28'b0, bus_if.bus_we}, {28'b0, sb_q[0].we});
                        check("bus_wdata_hold", bus_if.bus_wdata, sb_q[0].wdata);
                    end
                end
                if (stall_req === 1'b1) begin
                    run++;
                end else if (run > 0) begin
                    if (sb_q.size() == 0) begin
                        check("done_without_access", 32'(run), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("stall_cycles", 32'(run), 32'(e.stall));
                        check("req_cycles", 32'(req), 32'(e.req));
                        check("read_data", read_data, e.rd);
                        check("bus_err_done", {31'b0, bus_if.bus_err}, {31'b0, e.err});
                        check("bus_req_done", {31'b0, bus_if.bus_req}, 32'd0);
                        check("bus_we_done", {28'b0, bus_if.bus_we}, 32'd0);
                    end
                    run = 0;
                    req = 0;
                end else begin
                    check("bus_err_idle", {31'b0, bus_if.bus_err}, 32'd0);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0]  r_we, r_sel;
        logic [31:0] r_rdata;
        int          r_lat, pick;
        bit          r_b2b;

        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;

        // Reset with ram_en high: stall must stay low while in reset.
        rst    = 1'b0;
        ram_en = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_stall", {31'b0, stall_req}, 32'd0);
        check("rst_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
        check("rst_bus_we", {28'b0, bus_if.bus_we}, 32'd0);
        check("rst_bus_addr", bus_if.bus_addr, 32'd0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_bus_err", {31'b0, bus_if.bus_err}, 32'd0);
        ram_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Word load, same-cycle ack.
        do_access(4'b0000, 32'h100, 32'h0, 2'd0, 4'b1111, 1'b0, 32'hDEAD_BEEF, 1, 1'b0);
        // Byte loads, offset 3, ack on 4th REQ cycle.
        do_access(4'b0000, 32'h104, 32'h0, 2'd3, 4'b0001, 1'b1, 32'h80FF_0000, 4, 1'b0);
        do_access(4'b0000, 32'h104, 32'h0, 2'd3, 4'b0001, 1'b0, 32'h80FF_0000, 4, 1'b0);
        // Byte store: read_data must keep 0x80.
        do_access(4'b0100, 32'h204, 32'h00AB_0000, 2'd2, 4'b0001, 1'b0, 32'h1111_2222, 2, 1'b0);
        // Back-to-back load then store with ram_en held high.
        do_access(4'b0000, 32'h300, 32'h0, 2'd1, 4'b0001, 1'b1, 32'h0000_F500, 1, 1'b1);
        do_access(4'b0011, 32'h308, 32'h0000_5A5A, 2'd0, 4'b1111, 1'b0, 32'h0, 1, 1'b0);

        // Reset during REQ, then a stray ack after reset is released.
        ram_en = 1'b1; ram_write_en = 4'b0; ram_addr = 32'h500; mem_sel = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        ram_en = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        #2;
        check("abort_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
        check("abort_bus_addr", bus_if.bus_addr, 32'd0);
        check("abort_read_data", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #2;
        check("stray_ack_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
        check("stray_ack_stall", {31'b0, stall_req}, 32'd0);
        check("stray_ack_read_data", read_data, 32'd0);
        model_rd = 32'h0;
        @(negedge clk);

`ifdef DMEM_TIMEOUT_EN
        // No ack: forced completion after c_TO REQ cycles.
        do_access(4'b0000, 32'h600, 32'h0, 2'd0, 4'b1111, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
        // Ack on the last allowed cycle wins.
        do_access(4'b0000, 32'h600, 32'h0, 2'd0, 4'b1111, 1'b0, 32'hCAFE_F00D, c_TO, 1'b0);
`endif

        // Randomized accesses.
        for (int n = 0; n < 150; n++) begin
            r_we    = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            pick    = $urandom_range(0, 9);
            r_sel   = (pick < 4) ? 4'b0001 : (pick < 8) ? 4'b1111 : 4'($urandom);
            r_rdata = $urandom;
            r_lat   = $urandom_range(1, 6);
            r_b2b   = ($urandom_range(0, 1) == 1) && (n != 149);
            do_access(r_we, $urandom & 32'hFFFF_FFFC, $urandom, 2'($urandom), r_sel,
                      1'($urandom), r_rdata, r_lat, r_b2b);
            if (!r_b2b) begin
                ram_en = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        ram_en = 1'b0;

        for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
        if (sb_q.size() != 0) check("pending_accesses", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the MEM stage and consumes its RAM-control outputs: enable, per-byte write enables, word-aligned address and lane-shifted write data.
- Drives a request/acknowledge data-memory bus with variable latency.
- Holds the pipeline through stall_req until the access finishes.
- Returns load data to WB already extracted from the byte lane and sign- or zero-extended.

Parameters:
- DATA_WIDTH, 32, width of the data bus and of ram_write_data/read_data.
- ADDR_WIDTH, 32, width of the address bus.
- TIMEOUT_CYCLES, 255, maximum cycles in REQ before forced completion; only used with the optional feature.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- ram_en  in  1  access request from MEM.
- ram_write_en  in  4  byte write enables from MEM; 0 means a load.
- ram_addr  in  ADDR_WIDTH  word-aligned address from MEM.
- ram_write_data  in  DATA_WIDTH  lane-shifted store data from MEM.
- byte_offset  in  2  address[1:0] of the access.
- mem_sel  in  4  size: 4'b0001 = byte, 4'b1111 = word.
- mem_sign_ext  in  1  1 = sign-extend byte loads.
- stall_req  out  1  holds IF to MEM while an access is pending.
- read_data  out  DATA_WIDTH  aligned and extended load result to WB.
- bus_req  out  1  bus request.
- bus_we  out  4  bus byte write enables.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_ack  in  1  bus completion, 1-cycle pulse.
- bus_rdata  in  DATA_WIDTH  bus read data, valid while bus_ack=1.
- bus_err  out  1  timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, read_data=0, bus_err=0. stall_req=0 while rst=0. Reset mid-access aborts the bus cycle: bus_req drops on the next edge and any late bus_ack is ignored.
- FSM states:
  - IDLE: stall_req = ram_en (combinational). If ram_en=1, capture ram_addr, ram_write_en, ram_write_data, byte_offset, mem_sel and mem_sign_ext into internal registers, drive the bus outputs, and go to REQ.
  - REQ: bus_req=1; bus outputs hold the captured values, unaffected by input changes; stall_req=1. On bus_ack=1:
    - if it is a load (captured we==0), latch the extracted bus_rdata into read_data;
    - then go to DONE with bus_req=0 and bus_we=0.
  - DONE: stall_req=0 for exactly one cycle so the pipeline advances. Next state is IDLE. ram_en is not sampled in DONE, because it still reflects the finished access.
- Timing:
  - Minimum access is 3 cycles (IDLE, REQ with same-cycle ack, DONE), i.e. 2 stall cycles. Each extra cycle of ack latency adds one stall cycle.
  - Back-to-back accesses: the new ram_en is seen in the IDLE cycle after DONE.
- Load extraction:
  - Byte: read_data = lane (bus_rdata >> 8*offset)[7:0], extended per mem_sign_ext.
  - Word: read_data = bus_rdata.
  - Any other mem_sel: read_data = 0.
- read_data holds its value until the next load completes. Stores never change it.
- bus_ack outside REQ is ignored.
- bus_addr and bus_wdata keep their last values when idle. Only bus_req and bus_we carry meaning when idle.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT_CYCLES with no ack, go to DONE, set read_data=0 for a load, and pulse bus_err=1 for the DONE cycle.
  - An ack in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal completion, no error.
- DMEM_TIMEOUT_EN undefined: REQ waits indefinitely; bus_err is tied to 0; no counter logic is present.

Test Plan:
- Word load, addr 0x100, ack in the first REQ cycle, bus_rdata=0xDEADBEEF → stall_req high for 2 cycles; read_data=0xDEADBEEF in DONE; bus_req high for exactly 1 cycle.
- Byte load, offset 3, sign_ext=1, bus_rdata=0x80FF_0000, ack after 4 cycles → read_data=0xFFFFFF80; stall_req high for 5 cycles. Repeat with sign_ext=0 → 0x00000080.
- Byte store, we=4'b0100, wdata=0x00AB0000, ack after 2 cycles → bus_we=0100 and bus_wdata=0x00AB0000 held stable through REQ; read_data unchanged.
- Back-to-back: load then store with ram_en held high → bus_req sequence 1,0(DONE),0(IDLE),1; the second access uses the updated inputs.
- rst=0 asserted during REQ, then bus_ack pulsed after rst returns to 1 → outputs return to reset values, FSM in IDLE, stray ack ignored, read_data=0.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack → exactly 8 REQ cycles, then DONE with bus_err=1 and read_data=0. A second run with ack on cycle 8 → bus_err=0 and read_data=bus_rdata.
